// File: rtl/nn_axi_scratchpad.sv
// rtl/nn_axi_scratchpad.sv - AXI4 slave scratchpad for the neural accelerator's 64-bit master port
// Independent write/read FSMs share a dual-port word array; bad bursts finish with an error response.
module nn_axi_scratchpad #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int IDX_W  = MEM_WORDS_LOG2;
  localparam int TAG_LO = MEM_WORDS_LOG2 + 3;
  localparam int DEPTH  = 1 << MEM_WORDS_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  // Out-of-window decode wins over a malformed size/burst.
  function automatic logic [1:0] burst_class(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
    if (addr[ADDR_WIDTH-1:TAG_LO] != BASE_ADDR[ADDR_WIDTH-1:TAG_LO]) return RESP_DECERR;
    if (size != 3'd3 || burst > 2'd1) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                             s_axi_awaddr[2:0], s_axi_araddr[2:0]};

  logic [63:0] mem [DEPTH];

  // Write path
  logic [1:0]       w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [7:0]       w_cnt;
  logic             w_fixed;
  logic [1:0]       w_err;
  logic             w_last_bad;
  logic [1:0]       bresp_q;
  logic             aw_hs;
  logic             w_hs;
  logic             b_hs;
  logic             w_final;
  logic             w_bad_now;
  logic             mem_we;

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bresp   = bresp_q;

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign w_final   = (w_cnt == w_len);
  assign w_bad_now = (s_axi_wlast != w_final);
  assign mem_we    = w_hs && (w_err == RESP_OKAY);

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state    <= W_IDLE;
      w_idx      <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_fixed    <= 1'b0;
      w_err      <= RESP_OKAY;
      w_last_bad <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx      <= s_axi_awaddr[TAG_LO-1:3];
            w_len      <= s_axi_awlen;
            w_cnt      <= '0;
            w_fixed    <= (s_axi_awburst == 2'd0);
            w_err      <= burst_class(s_axi_awaddr, s_axi_awsize, s_axi_awburst);
            w_last_bad <= 1'b0;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) w_idx <= w_idx + 1'b1;
            // The beat count, not wlast, ends the burst; a wlast mismatch only taints the response.
            if (w_final) begin
              w_state <= W_RESP;
              if (w_err != RESP_OKAY) bresp_q <= w_err;
              else if (w_last_bad || w_bad_now) bresp_q <= RESP_SLVERR;
              else bresp_q <= RESP_OKAY;
            end else begin
              w_last_bad <= w_last_bad | w_bad_now;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read path
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic             r_fixed;
  logic [1:0]       r_err;
  logic [63:0]      mem_q;
  logic             ar_hs;
  logic             r_hs;
  logic             r_final;
  logic             rd_en;

  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rresp   = s_axi_rvalid ? r_err : RESP_OKAY;
  assign s_axi_rlast   = s_axi_rvalid && r_final;
  assign s_axi_rdata   = (s_axi_rvalid && r_err == RESP_OKAY) ? mem_q : 64'd0;

  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign r_final = (r_cnt == r_len);
  // mem_q only reloads on a beat handshake, so it doubles as the stall-stable output holding register.
  assign rd_en   = (r_state == R_FETCH) || (r_hs && !r_final);

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_err   <= RESP_OKAY;
    end else begin
      if (rd_en && !r_fixed) r_idx <= r_idx + 1'b1;
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx   <= s_axi_araddr[TAG_LO-1:3];
            r_len   <= s_axi_arlen;
            r_cnt   <= '0;
            r_fixed <= (s_axi_arburst == 2'd0);
            r_err   <= burst_class(s_axi_araddr, s_axi_arsize, s_axi_arburst);
            r_state <= R_FETCH;
          end
        end
        R_FETCH: r_state <= R_DATA;
        R_DATA: begin
          if (r_hs) begin
            if (r_final) r_state <= R_IDLE;
            else r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rd_en) mem_q <= mem[r_idx];
  end

endmodule

// File: tb/tb_nn_axi_scratchpad.sv
// tb/tb_nn_axi_scratchpad.sv - directed self-checking bench for nn_axi_scratchpad
module tb_nn_axi_scratchpad;
  localparam int LIMIT = 64;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_areset = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  nn_axi_scratchpad dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0),
    .s_axi_awprot(3'd0), .s_axi_awqos(4'd0), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0),
    .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int tests = 0;
  int fails = 0;
  int timeouts = 0;
  int lat_w, lat_b, lat_r, stall_bad, aw_low, ar_back, post_rvalid, n_dummy;
  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [1:0]  resp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeouts++;
    tick();
    s_axi_awvalid = 1'b0;
    aw_low = int'(s_axi_awready == 1'b0);
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        output int waits);
    int n = 0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeouts++;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    waits = n;
  endtask

  task automatic b_recv(output logic [1:0] r, output int waits);
    int n = 0;
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeouts++;
    r = s_axi_bresp;
    tick();
    s_axi_bready = 1'b0;
    waits = n;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] strb, input bit early,
                           output logic [1:0] r);
    int n;
    aw_send(addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      w_beat(wbuf[i], strb, early ? (i == 0) : (i == int'(len)), n);
      if (i == 0) lat_w = n;
    end
    b_recv(r, lat_b);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit toggle);
    int n = 0;
    int nb = 0;
    int cyc = 0;
    bit held = 0;
    logic [63:0] hd;
    logic [1:0] hr;
    logic hl;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeouts++;
    tick();
    s_axi_arvalid = 1'b0;
    lat_r = 0;
    while (!s_axi_rvalid && lat_r < LIMIT) begin tick(); lat_r++; end
    stall_bad = 0;
    while (nb <= int'(len) && cyc < 4 * LIMIT) begin
      s_axi_rready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (s_axi_rvalid) begin
        if (held && (s_axi_rdata !== hd || s_axi_rresp !== hr || s_axi_rlast !== hl)) stall_bad++;
        if (s_axi_rready) begin
          rbuf[nb] = s_axi_rdata; rrsp[nb] = s_axi_rresp; rlst[nb] = s_axi_rlast;
          nb++; held = 0;
        end else begin
          held = 1; hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast;
        end
      end
      tick();
      cyc++;
    end
    if (nb <= int'(len)) timeouts++;
    s_axi_rready = 1'b0;
    ar_back = int'(s_axi_arready);
    post_rvalid = int'(s_axi_rvalid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_rdata", s_axi_rdata, 0);
    s_axi_areset = 1'b0;
    tick();

    // INCR write of 4 beats then readback
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    axi_write(32'h4000_0010, 8'd3, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    check("incr_bresp", resp, 0);
    check("incr_awready_low", aw_low, 1);
    check("incr_wready_lat", lat_w, 0);
    check("incr_bvalid_lat", lat_b, 0);
    check("incr_awready_back", s_axi_awready, 1);
    axi_read(32'h4000_0010, 8'd3, 3'd3, 2'd1, 1'b0);
    check("incr_rvalid_lat", lat_r, 1);
    check("incr_rdata0", rbuf[0], 64'h11);
    check("incr_rdata1", rbuf[1], 64'h22);
    check("incr_rdata2", rbuf[2], 64'h33);
    check("incr_rdata3", rbuf[3], 64'h44);
    check("incr_rlast", {rlst[0], rlst[1], rlst[2], rlst[3]}, 4'b0001);
    check("incr_rresp", {rrsp[0], rrsp[3]}, 4'b0000);
    check("incr_arready_back", ar_back, 1);

    // byte strobes on word 5
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(32'h4000_0028, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    wbuf[0] = 64'h0;
    axi_write(32'h4000_0028, 8'd0, 3'd3, 2'd1, 8'h0F, 1'b0, resp);
    axi_read(32'h4000_0028, 8'd0, 3'd3, 2'd1, 1'b0);
    check("strb_rdata", rbuf[0], 64'hFFFF_FFFF_0000_0000);

    // 8-beat read under rready backpressure
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 + 64'(i * 16 + 1);
    axi_write(32'h4000_0080, 8'd7, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    axi_read(32'h4000_0080, 8'd7, 3'd3, 2'd1, 1'b1);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_rdata%0d", i), rbuf[i], 64'hC0DE_0000_0000_0000 + 64'(i * 16 + 1));
    check("bp_rlast", {rlst[6], rlst[7]}, 2'b01);
    check("bp_stable", stall_bad, 0);
    check("bp_no_extra", post_rvalid, 0);

    // error responses
    wbuf[0] = 64'h1234;
    axi_write(32'h4000_0000, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    wbuf[0] = 64'hDEAD;
    axi_write(32'h5000_0000, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    check("err_decerr_bresp", resp, 2'b11);
    axi_read(32'h4000_0000, 8'd0, 3'd3, 2'd1, 1'b0);
    check("err_mem_unchanged", rbuf[0], 64'h1234);
    axi_write(32'h4000_0048, 8'd0, 3'd2, 2'd1, 8'hFF, 1'b0, resp);
    check("err_size_bresp", resp, 2'b10);
    wbuf[0] = 64'h5; wbuf[1] = 64'h6;
    axi_write(32'h4000_0048, 8'd1, 3'd3, 2'd1, 8'hFF, 1'b1, resp);
    check("err_wlast_bresp", resp, 2'b10);
    axi_read(32'h6000_0000, 8'd1, 3'd3, 2'd1, 1'b0);
    check("err_rd_rdata", {rbuf[0], rbuf[1]}, 128'h0);
    check("err_rd_rresp", {rrsp[0], rrsp[1]}, 4'b1111);
    check("err_rd_rlast", {rlst[0], rlst[1]}, 2'b01);

    // INCR wrap at the top of the array, then FIXED
    wbuf[0] = 64'hAAAA; wbuf[1] = 64'hBBBB;
    axi_write(32'h4000_7FF8, 8'd1, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    check("wrap_bresp", resp, 0);
    axi_read(32'h4000_0000, 8'd0, 3'd3, 2'd1, 1'b0);
    check("wrap_word0", rbuf[0], 64'hBBBB);
    axi_read(32'h4000_7FF8, 8'd1, 3'd3, 2'd1, 1'b0);
    check("wrap_rd", {rbuf[0], rbuf[1]}, {64'hAAAA, 64'hBBBB});
    wbuf[0] = 64'h88;
    axi_write(32'h4000_0040, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    wbuf[0] = 64'h71; wbuf[1] = 64'h72; wbuf[2] = 64'h73;
    axi_write(32'h4000_0038, 8'd2, 3'd3, 2'd0, 8'hFF, 1'b0, resp);
    check("fixed_bresp", resp, 0);
    axi_read(32'h4000_0038, 8'd1, 3'd3, 2'd1, 1'b0);
    check("fixed_word7", rbuf[0], 64'h73);
    check("fixed_word8", rbuf[1], 64'h88);

    // reset in the middle of a write burst
    aw_send(32'h4000_0100, 8'd3, 3'd3, 2'd1);
    w_beat(64'h9001, 8'hFF, 1'b0, n_dummy);
    w_beat(64'h9002, 8'hFF, 1'b0, n_dummy);
    s_axi_areset = 1'b1;
    #1;
    check("midrst_awready", s_axi_awready, 1);
    check("midrst_wready", s_axi_wready, 0);
    check("midrst_bvalid", s_axi_bvalid, 0);
    tick(); tick();
    s_axi_areset = 1'b0;
    tick();
    wbuf[0] = 64'hE0; wbuf[1] = 64'hE1;
    axi_write(32'h4000_0140, 8'd1, 3'd3, 2'd1, 8'hFF, 1'b0, resp);
    check("postrst_bresp", resp, 0);
    axi_read(32'h4000_0140, 8'd1, 3'd3, 2'd1, 1'b0);
    check("postrst_rd", {rbuf[0], rbuf[1]}, {64'hE0, 64'hE1});
    axi_read(32'h4000_0100, 8'd1, 3'd3, 2'd1, 1'b0);
    check("midrst_partial", {rbuf[0], rbuf[1]}, {64'h9001, 64'h9002});

    check("timeouts", timeouts, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
